vec_irq_arbiter: RTL and testbench
==================================

Name: vec_irq_arbiter

Overview:
- Vectored-interrupt arbiter that sits directly upstream of the processor board's interrupt port. It drives virq and ivec, and answers istb with iack.
- Collects level-sensitive requests from N peripheral devices (serial ports, disk controllers, line clock) and selects one by priority.
- Runs the vector handshake with the CPU, then returns a one-cycle acknowledge to the serviced device so the device can clear its request.

Parameters:
- N, 8: number of request sources; index 0 has the highest priority.
- SPUR_VEC, 16'o000000: vector returned when istb arrives with no request pending.

Ports:
- clk_p  in  1  system clock, positive phase.
- rst  in  1  synchronous, active-high reset (top level ties it to vm_init|dclo).
- irq_req  in  N  level request from each device.
- irq_vec  in  16*N  packed vectors; source i occupies bits [16*i+15:16*i].
- irq_ack  out  N  one-cycle pulse to the serviced device.
- virq  out  1  vectored interrupt request to the CPU.
- istb  in  1  vector fetch strobe from the CPU.
- ivec  out  16  vector presented to the CPU.
- iack  out  1  vector acknowledge to the CPU.
- busy  out  1  high in any state other than IDLE (debug/LED).

Behaviour:
- One clock, clk_p. Reset is synchronous and active-high: on rst, state=IDLE, virq=0, iack=0, ivec=0, irq_ack=0, busy=0, winner=0. Reset mid-handshake aborts the handshake; no irq_ack is issued.
- Winner = lowest set index of irq_req (fixed priority).
- States:
  - IDLE: if |irq_req, latch winner, set virq=1, go to REQ (virq rises 1 cycle after the request).
  - REQ: re-arbitrate every cycle while istb=0, so a higher-priority request can pre-empt. If irq_req==0, set virq=0 and return to IDLE (request withdrawn). When istb=1, freeze winner, load ivec=irq_vec[winner] (SPUR_VEC if irq_req==0 that cycle), assert iack next cycle, go to ACK.
  - ACK: hold iack=1 and keep ivec stable while istb=1. When istb=0: iack=0, virq=0, pulse irq_ack[winner] for 1 cycle (none if spurious), go to GAP.
  - GAP: 1 dead cycle so the device can drop its request, then return to IDLE.
- Latency: istb sampled high at cycle t gives iack=1 at t+1; irq_ack at t+2 relative to istb falling at t+1.
- virq stays high until istb falls. A requester that drops its request after istb still gets its frozen vector and receives irq_ack.
- Simultaneous requests: lowest index wins; the others remain pending and are serviced in later rounds.
- istb asserted while in IDLE (spurious): respond with SPUR_VEC/iack through ACK so the CPU never hangs.
- ivec is held at its last value outside ACK; it is meaningful only while iack=1.

Optional Feature:
- Macro INTC_ROUND_ROBIN_EN.
- Defined: rotating priority. Pointer ptr (log2 N bits, reset 0) is set to winner+1 (mod N) on each non-spurious irq_ack. Arbitration searches from ptr upward with wrap-around.
- Undefined: fixed priority; ptr does not exist.

Decomposition:
- Package intc_pkg: state encoding (IDLE, REQ, ACK, GAP), VEC_W=16, and a function for the clog2 pointer width.
- One sub-module, intc_prio_enc: combinational find-first-set over N bits with a rotating base input (base tied to 0 in fixed mode). Outputs index and valid.

Test Plan:
- Single source: irq_req=8'b0000_0100, vec2=16'o000060. Expect virq=1 next cycle. Raise istb; iack=1 one cycle later with ivec=16'o000060. Drop istb; expect irq_ack=8'b0000_0100 for 1 cycle and virq=0.
- Priority and pre-emption: req3 asserted, then req1 asserted while in REQ before istb. Expect ivec=vec1 and irq_ack[1]. req3 is then serviced in the next round.
- Withdrawal: req5 pulsed for 2 cycles with no istb. Expect virq to fall, state back to IDLE, and no irq_ack.
- Spurious: istb raised with irq_req=0. Expect iack=1 with ivec=16'o000000 and no irq_ack bit set.
- Reset mid-ACK: rst asserted while iack=1. Next cycle iack=0, virq=0, busy=0; irq_ack is never pulsed.
- INTC_ROUND_ROBIN_EN: req0 and req4 held continuously. Service order must alternate 0,4,0,4 across 4 handshakes; fixed mode gives 0,0,0,0.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the vectored-interrupt arbiter.
//   state_t : handshake FSM encoding (IDLE, REQ, ACK, GAP)
//   VEC_W   : width of one interrupt vector
//   ptr_w() : width of a source index / rotating pointer for n sources
package intc_pkg;

  localparam int VEC_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_t;

  // A single source still needs a one-bit index so the ports never collapse.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Find-first-set over N request bits, searching upward from 'base' with
// wrap-around. With base tied to 0 this is a plain fixed-priority encoder
// where index 0 wins.
//   req   : request bits
//   base  : index where the search starts (must be < N)
//   idx   : index of the first set bit at or above base (wrapping)
//   valid : high when any request bit is set
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int            pos;
  logic [IW-1:0] pos_idx;

  always_comb begin
    idx     = '0;
    valid   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(base) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = IW'(pos);
      if (!valid && req[pos_idx]) begin
        valid = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/vec_irq_arbiter.sv
// Vectored-interrupt arbiter placed in front of the CPU interrupt port.
// Collects level requests from N devices, raises virq, answers the CPU's
// istb with ivec/iack, then pulses irq_ack to the serviced device.
//
// Ports:
//   clk_p   : system clock
//   rst     : synchronous active-high reset
//   irq_req : level request per device (index 0 = highest fixed priority)
//   irq_vec : packed vectors, source i at [16*i+15:16*i]
//   irq_ack : one-cycle acknowledge pulse to the serviced device
//   virq    : vectored interrupt request to the CPU
//   istb    : vector fetch strobe from the CPU
//   ivec    : vector presented to the CPU (meaningful while iack=1)
//   iack    : vector acknowledge to the CPU
//   busy    : FSM is not in IDLE
//
// Handshake: virq requests service; the CPU raises istb, the arbiter
// answers with iack=1 one cycle later and holds ivec stable until istb
// falls, after which iack and virq drop together.
//
// Build option: define INTC_ROUND_ROBIN_EN for rotating priority (search
// starts one past the last serviced source). Without it, priority is fixed.
module vec_irq_arbiter
  import intc_pkg::*;
#(
  parameter int               N        = 8,
  parameter logic [VEC_W-1:0] SPUR_VEC = 16'o000000
) (
  input  logic               clk_p,
  input  logic               rst,
  input  logic [N-1:0]       irq_req,
  input  logic [VEC_W*N-1:0] irq_vec,
  output logic [N-1:0]       irq_ack,
  output logic               virq,
  input  logic               istb,
  output logic [VEC_W-1:0]   ivec,
  output logic               iack,
  output logic               busy
);

  localparam int IW = ptr_w(N);

  state_t           state, state_d;
  logic             virq_d, iack_d;
  logic [VEC_W-1:0] ivec_d;
  logic [N-1:0]     ack_d;
  logic [IW-1:0]    winner, winner_d;
  logic             spur, spur_d;

  logic [IW-1:0]    enc_base;
  logic [IW-1:0]    enc_idx;
  logic             enc_valid;
  logic [VEC_W-1:0] vec_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign vec_arr[i] = irq_vec[VEC_W*i +: VEC_W];
  end

`ifdef INTC_ROUND_ROBIN_EN
  logic [IW-1:0] ptr, ptr_d;
  assign enc_base = ptr;
`else
  assign enc_base = '0;
`endif

  intc_prio_enc #(.N(N), .IW(IW)) u_enc (
    .req   (irq_req),
    .base  (enc_base),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_d  = state;
    virq_d   = virq;
    iack_d   = iack;
    ivec_d   = ivec;
    ack_d    = '0;
    winner_d = winner;
    spur_d   = spur;
`ifdef INTC_ROUND_ROBIN_EN
    ptr_d    = ptr;
`endif
    case (state)
      IDLE: begin
        if (istb) begin
          // CPU fetching without a pending virq: still complete the
          // handshake so the CPU never stalls.
          winner_d = enc_idx;
          spur_d   = !enc_valid;
          ivec_d   = enc_valid ? vec_arr[enc_idx] : SPUR_VEC;
          iack_d   = 1'b1;
          state_d  = ACK;
        end else if (enc_valid) begin
          winner_d = enc_idx;
          virq_d   = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (istb) begin
          // Winner is frozen here; later request changes do not matter.
          winner_d = enc_idx;
          spur_d   = !enc_valid;
          ivec_d   = enc_valid ? vec_arr[enc_idx] : SPUR_VEC;
          iack_d   = 1'b1;
          state_d  = ACK;
        end else if (!enc_valid) begin
          virq_d  = 1'b0;
          state_d = IDLE;
        end else begin
          winner_d = enc_idx;
        end
      end
      ACK: begin
        if (!istb) begin
          iack_d  = 1'b0;
          virq_d  = 1'b0;
          state_d = GAP;
          if (!spur) begin
            ack_d[winner] = 1'b1;
`ifdef INTC_ROUND_ROBIN_EN
            ptr_d = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
`endif
          end
        end
      end
      GAP: begin
        // Dead cycle lets the device drop its request before re-arbitration.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (rst) begin
      state   <= IDLE;
      virq    <= 1'b0;
      iack    <= 1'b0;
      ivec    <= '0;
      irq_ack <= '0;
      winner  <= '0;
      spur    <= 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
      ptr     <= '0;
`endif
    end else begin
      state   <= state_d;
      virq    <= virq_d;
      iack    <= iack_d;
      ivec    <= ivec_d;
      irq_ack <= ack_d;
      winner  <= winner_d;
      spur    <= spur_d;
`ifdef INTC_ROUND_ROBIN_EN
      ptr     <= ptr_d;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_vec_irq_arbiter.sv
module tb_vec_irq_arbiter;

  logic         clk_p = 1'b0;
  logic         rst;
  logic [7:0]   irq_req;
  logic [127:0] irq_vec;
  logic [7:0]   irq_ack;
  logic         virq;
  logic         istb;
  logic [15:0]  ivec;
  logic         iack;
  logic         busy;

  logic [15:0]  vecs [8];
  logic [15:0]  exp_vec_q [$];
  logic [7:0]   exp_ack_q [$];
  int           exp_order [4];
  int           n_vec  = 0;
  int           n_miss = 0;
  logic         prev_iack = 1'b0;

  // clock
  always #5 clk_p = ~clk_p;

  always_comb begin
    for (int i = 0; i < 8; i++) irq_vec[16*i +: 16] = vecs[i];
  end

  vec_irq_arbiter #(.N(8), .SPUR_VEC(16'o000000)) dut (
    .clk_p   (clk_p),
    .rst     (rst),
    .irq_req (irq_req),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack),
    .virq    (virq),
    .istb    (istb),
    .ivec    (ivec),
    .iack    (iack),
    .busy    (busy)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic wait_virq();
    for (int i = 0; i < 10 && !virq; i++) step();
    chk("virq_wait", {15'd0, virq}, 16'd1);
  endtask

  // scoreboard monitor: ivec on each iack rise, irq_ack on each pulse
  always @(negedge clk_p) begin
    if (iack === 1'b1 && prev_iack === 1'b0) begin
      if (exp_vec_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL ivec_unexpected: got %0h expected none", ivec);
      end else begin
        chk("ivec", ivec, exp_vec_q.pop_front());
      end
    end
    if (irq_ack !== 8'd0) begin
      if (exp_ack_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL irq_ack_unexpected: got %0h expected 0", irq_ack);
      end else begin
        chk("irq_ack", {8'd0, irq_ack}, {8'd0, exp_ack_q.pop_front()});
      end
    end
    prev_iack = iack;
  end

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = 16'o000050 + 16'(4 * i);
`ifdef INTC_ROUND_ROBIN_EN
    exp_order = '{0, 4, 0, 4};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    rst = 1'b1; irq_req = 8'd0; istb = 1'b0;
    repeat (3) step();
    chk("rst_virq", {15'd0, virq}, 16'd0);
    chk("rst_iack", {15'd0, iack}, 16'd0);
    chk("rst_ivec", ivec, 16'd0);
    chk("rst_irq_ack", {8'd0, irq_ack}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    step();

    // single source
    irq_req = 8'b0000_0100;
    step();
    chk("t1_virq", {15'd0, virq}, 16'd1);
    chk("t1_busy", {15'd0, busy}, 16'd1);
    istb = 1'b1;
    exp_vec_q.push_back(16'o000060);
    exp_ack_q.push_back(8'b0000_0100);
    step();
    chk("t1_iack", {15'd0, iack}, 16'd1);
    step();
    chk("t1_iack_hold", {15'd0, iack}, 16'd1);
    chk("t1_ivec_hold", ivec, 16'o000060);
    istb = 1'b0;
    step();
    chk("t1_iack_off", {15'd0, iack}, 16'd0);
    chk("t1_virq_off", {15'd0, virq}, 16'd0);
    irq_req = 8'd0;
    step();
    chk("t1_ack_width", {8'd0, irq_ack}, 16'd0);
    chk("t1_idle", {15'd0, busy}, 16'd0);

    // priority and pre-emption, then the loser is serviced
    irq_req = 8'b0000_1000;
    step();
    chk("t2_virq", {15'd0, virq}, 16'd1);
    irq_req = 8'b0000_1010;
    step();
    istb = 1'b1;
    exp_vec_q.push_back(vecs[1]);
    exp_ack_q.push_back(8'b0000_0010);
    step();
    istb = 1'b0;
    step();
    irq_req = 8'b0000_1000;
    step();
    wait_virq();
    istb = 1'b1;
    exp_vec_q.push_back(vecs[3]);
    exp_ack_q.push_back(8'b0000_1000);
    step();
    // requester drops after istb: still acked with frozen vector
    irq_req = 8'd0;
    step();
    chk("t2_ivec_frozen", ivec, vecs[3]);
    istb = 1'b0;
    step(); step();

    // withdrawal
    irq_req = 8'b0010_0000;
    step();
    chk("t3_virq", {15'd0, virq}, 16'd1);
    step();
    irq_req = 8'd0;
    step();
    chk("t3_virq_off", {15'd0, virq}, 16'd0);
    chk("t3_idle", {15'd0, busy}, 16'd0);
    step(); step();

    // spurious
    istb = 1'b1;
    exp_vec_q.push_back(16'o000000);
    step();
    chk("t4_iack", {15'd0, iack}, 16'd1);
    istb = 1'b0;
    step();
    chk("t4_iack_off", {15'd0, iack}, 16'd0);
    step(); step();

    // reset mid-ACK
    irq_req = 8'b0000_0001;
    step();
    istb = 1'b1;
    exp_vec_q.push_back(vecs[0]);
    step();
    chk("t5_iack", {15'd0, iack}, 16'd1);
    rst = 1'b1;
    step();
    chk("t5_iack", {15'd0, iack}, 16'd0);
    chk("t5_virq", {15'd0, virq}, 16'd0);
    chk("t5_busy", {15'd0, busy}, 16'd0);
    chk("t5_ivec", ivec, 16'd0);
    rst = 1'b0; istb = 1'b0; irq_req = 8'd0;
    step(); step(); step();

    // two sources held continuously: service order
    irq_req = 8'b0001_0001;
    for (int r = 0; r < 4; r++) begin
      wait_virq();
      istb = 1'b1;
      exp_vec_q.push_back(vecs[exp_order[r]]);
      exp_ack_q.push_back(8'(1 << exp_order[r]));
      step();
      istb = 1'b0;
      step(); step();
    end
    irq_req = 8'd0;
    repeat (4) step();

    chk("vec_q_drained", 16'(exp_vec_q.size()), 16'd0);
    chk("ack_q_drained", 16'(exp_ack_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
